// File: rtl/mbox_mem_arb_if.sv
// MBOX memory arbiter bus: channel/CCA/EBOX requests in, SBUS start and
// status out. master = requester/memory side, slave = arbiter.
interface mbox_mem_arb_if;
   logic       chan_rq;
   logic       chan_wr;
   logic       cca_rq;
   logic       ebox_rq;
   logic       ebox_wr;
   logic [3:0] wd_mask;
   logic       ackn;
   logic       data_valid;
   logic       nxm_clr;
   logic [2:0] grant;
   logic       mem_start;
   logic       mem_wr;
   logic       core_busy;
   logic       done;
   logic       nxm_err;
   logic [7:0] nxm_cnt;

   modport master (
      output chan_rq, chan_wr, cca_rq, ebox_rq, ebox_wr,
      output wd_mask, ackn, data_valid, nxm_clr,
      input  grant, mem_start, mem_wr, core_busy,
      input  done, nxm_err, nxm_cnt
   );

   modport slave (
      input  chan_rq, chan_wr, cca_rq, ebox_rq, ebox_wr,
      input  wd_mask, ackn, data_valid, nxm_clr,
      output grant, mem_start, mem_wr, core_busy,
      output done, nxm_err, nxm_cnt
   );
endinterface

// File: rtl/mbox_mem_arb.sv
// MBOX memory arbiter: fixed priority CHAN > CCA > EBOX, one memory cycle
// at a time, registered outputs, optional NXM timeout.
// Ports: clk, reset_n (sync, active-low), bus (mbox_mem_arb_if.slave).
// Define MBOX_MEM_ARB_NXM_TIMEOUT_EN to build the NXM_LIMIT timeout.
module mbox_mem_arb #(
   parameter logic [7:0] NXM_LIMIT = 8'd64
) (
   input  logic            clk,
   input  logic            reset_n,
   mbox_mem_arb_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_RDWAIT, S_NXM, S_DONE
   } state_t;

   state_t     state, state_nxt;
   logic [2:0] grant_q, grant_d;
   logic       mem_wr_q, mem_wr_d;
   logic [2:0] words_q, words_d;
   logic       mem_start_q, mem_start_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [7:0] nxm_cnt_q;
   logic       nxm_err_q;
   logic       nxm_hit;
   logic       any_rq;
   logic       grant_now;
   logic [2:0] pop;

   assign any_rq    = bus.chan_rq | bus.cca_rq | bus.ebox_rq;
   assign grant_now = (state == S_IDLE) && (state_nxt == S_START);
   assign pop = {2'b0, bus.wd_mask[0]} + {2'b0, bus.wd_mask[1]}
              + {2'b0, bus.wd_mask[2]} + {2'b0, bus.wd_mask[3]};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         grant_q     <= 3'b000;
         mem_wr_q    <= 1'b0;
         words_q     <= 3'd0;
         mem_start_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state       <= state_nxt;
         grant_q     <= grant_d;
         mem_wr_q    <= mem_wr_d;
         words_q     <= words_d;
         mem_start_q <= mem_start_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (any_rq) state_nxt = S_START;
         S_START: begin
            // ACKN beats the timeout when both land together
            if (bus.ackn)
               state_nxt = mem_wr_q ? S_DONE : S_RDWAIT;
            else if (nxm_hit)
               state_nxt = S_NXM;
         end
         S_RDWAIT: begin
            if (bus.data_valid && words_q == 3'd1)
               state_nxt = S_DONE;
         end
         S_NXM:    state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      grant_d     = grant_q;
      mem_wr_d    = mem_wr_q;
      words_d     = words_q;
      mem_start_d = (state_nxt == S_START);
      busy_d      = (state_nxt != S_IDLE);
      done_d      = (state_nxt == S_DONE);
      if (grant_now) begin
         if (bus.chan_rq) begin
            grant_d  = 3'b100;
            mem_wr_d = bus.chan_wr;
         end else if (bus.cca_rq) begin
            grant_d  = 3'b010;
            mem_wr_d = 1'b1;
         end else begin
            grant_d  = 3'b001;
            mem_wr_d = bus.ebox_wr;
         end
         // an empty read mask means a full four-word read
         words_d = (bus.wd_mask == 4'b0000) ? 3'd4 : pop;
      end else if (state_nxt == S_IDLE) begin
         grant_d  = 3'b000;
         mem_wr_d = 1'b0;
      end
      if (state == S_RDWAIT && bus.data_valid)
         words_d = words_q - 3'd1;
   end

`ifdef MBOX_MEM_ARB_NXM_TIMEOUT_EN
   assign nxm_hit = (nxm_cnt_q == NXM_LIMIT - 8'd1);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         nxm_cnt_q <= 8'd0;
         nxm_err_q <= 1'b0;
      end else begin
         if (grant_now)
            nxm_cnt_q <= 8'd0;
         else if (state == S_START && !bus.ackn && !nxm_hit)
            nxm_cnt_q <= nxm_cnt_q + 8'd1;
         // a new NXM outranks a clear in the same cycle
         if (state == S_START && state_nxt == S_NXM)
            nxm_err_q <= 1'b1;
         else if (bus.nxm_clr)
            nxm_err_q <= 1'b0;
      end
   end
`else
   logic unused_nxm;
   assign unused_nxm = ^{NXM_LIMIT, bus.nxm_clr};
   assign nxm_hit    = 1'b0;
   assign nxm_cnt_q  = 8'd0;
   assign nxm_err_q  = 1'b0;
`endif

   assign bus.grant     = grant_q;
   assign bus.mem_start = mem_start_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.core_busy = busy_q;
   assign bus.done      = done_q;
   assign bus.nxm_err   = nxm_err_q;
   assign bus.nxm_cnt   = nxm_cnt_q;

endmodule

// File: tb/tb_mbox_mem_arb.sv
// Testbench for mbox_mem_arb: vector table, hand sequences for NXM and
// reset corners, and random transactions against a transaction model.
module tb_mbox_mem_arb;

   logic clk;
   logic reset_n;
   int   n_tests;
   int   n_fail;

   mbox_mem_arb_if bus ();

   mbox_mem_arb #(.NXM_LIMIT(8'd64)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog time limit expired");
      $fatal(1);
   end

   typedef struct {
      logic [2:0] rq;
      logic [2:0] wr;
      logic [3:0] mask;
      int         ackd;
      logic [2:0] eg;
      logic       ew;
      int         ewords;
   } vec_t;

   vec_t vecs[9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic set_rq(input logic [2:0] rq, input logic [2:0] wr,
                         input logic [3:0] mask);
      bus.chan_rq = rq[2];
      bus.cca_rq  = rq[1];
      bus.ebox_rq = rq[0];
      bus.chan_wr = wr[2];
      bus.ebox_wr = wr[0];
      bus.wd_mask = mask;
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_grant"}, {29'd0, bus.grant}, 32'd0);
      chk({nm, "_busy"}, {31'd0, bus.core_busy}, 32'd0);
      chk({nm, "_done"}, {31'd0, bus.done}, 32'd0);
      chk({nm, "_mstart"}, {31'd0, bus.mem_start}, 32'd0);
      chk({nm, "_mwr"}, {31'd0, bus.mem_wr}, 32'd0);
   endtask

   // Transaction-level reference: owner by priority, writes finish one
   // cycle after ACKN, reads one cycle after the last expected word.
   function automatic logic [2:0] m_owner(input logic [2:0] rq);
      if (rq[2])      return 3'b100;
      else if (rq[1]) return 3'b010;
      else            return 3'b001;
   endfunction

   function automatic logic m_wr(input logic [2:0] rq,
                                 input logic [2:0] wr);
      if (rq[2])      return wr[2];
      else if (rq[1]) return 1'b1;
      else            return wr[0];
   endfunction

   function automatic int m_words(input logic [3:0] mask);
      return (mask == 4'b0000) ? 4 : $countones(mask);
   endfunction

   task automatic do_txn(input logic [2:0] rq, input logic [2:0] wr,
                         input logic [3:0] mask, input int ackd,
                         input logic [2:0] eg, input logic ew,
                         input int ewords, input bit noisy);
      set_rq(rq, wr, mask);
      bus.ackn       = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.data_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      chk("grant", {29'd0, bus.grant}, {29'd0, eg});
      chk("mstart", {31'd0, bus.mem_start}, 32'd1);
      chk("mem_wr", {31'd0, bus.mem_wr}, {31'd0, ew});
      chk("busy", {31'd0, bus.core_busy}, 32'd1);
      bus.ackn = 1'b0;
      for (int i = 0; i < ackd; i++) begin
         if (noisy) begin
            set_rq(3'($urandom), 3'($urandom), 4'($urandom));
            bus.data_valid = 1'($urandom_range(0, 1));
         end
         tick();
         chk("start_hold", {28'd0, bus.mem_start, bus.grant},
             {28'd1, eg});
      end
      bus.ackn = 1'b1;
      tick();
      bus.ackn = 1'b0;
      bus.data_valid = 1'b0;
      chk("start_end", {31'd0, bus.mem_start}, 32'd0);
      if (ew) begin
         chk("wr_done", {28'd0, bus.done, bus.grant}, {28'd1, eg});
      end else begin
         chk("rd_wait", {30'd0, bus.done, bus.core_busy}, 32'd1);
         for (int w = 1; w <= ewords; w++) begin
            int g;
            g = noisy ? int'($urandom_range(0, 2)) : 0;
            for (int k = 0; k < g; k++) begin
               tick();
               chk("rd_gap", {31'd0, bus.done}, 32'd0);
            end
            bus.data_valid = 1'b1;
            tick();
            bus.data_valid = 1'b0;
            chk("rd_word", {28'd0, bus.done, bus.grant},
                {28'd0, (w == ewords), eg});
         end
      end
      if (noisy) begin
         set_rq(3'($urandom), 3'($urandom), 4'($urandom));
         bus.ackn       = 1'($urandom_range(0, 1));
         bus.data_valid = 1'($urandom_range(0, 1));
      end
      tick();
      bus.ackn       = 1'b0;
      bus.data_valid = 1'b0;
      chk_idle("after_done");
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      vecs[0] = '{3'b001, 3'b001, 4'b0000, 2, 3'b001, 1'b1, 0};
      vecs[1] = '{3'b111, 3'b100, 4'b0000, 0, 3'b100, 1'b1, 0};
      vecs[2] = '{3'b011, 3'b000, 4'b0000, 1, 3'b010, 1'b1, 0};
      vecs[3] = '{3'b001, 3'b000, 4'b0101, 1, 3'b001, 1'b0, 2};
      vecs[4] = '{3'b001, 3'b000, 4'b0000, 0, 3'b001, 1'b0, 4};
      vecs[5] = '{3'b110, 3'b000, 4'b1000, 3, 3'b100, 1'b0, 1};
      vecs[6] = '{3'b011, 3'b001, 4'b0111, 0, 3'b010, 1'b1, 0};
      vecs[7] = '{3'b101, 3'b001, 4'b0011, 2, 3'b100, 1'b0, 2};
      vecs[8] = '{3'b001, 3'b000, 4'b1111, 5, 3'b001, 1'b0, 4};

      reset_n        = 1'b0;
      set_rq(3'b000, 3'b000, 4'b0000);
      bus.ackn       = 1'b0;
      bus.data_valid = 1'b0;
      bus.nxm_clr    = 1'b0;
      tick();
      tick();
      chk_idle("reset");
      chk("reset_err", {31'd0, bus.nxm_err}, 32'd0);
      chk("reset_cnt", {24'd0, bus.nxm_cnt}, 32'd0);
      reset_n = 1'b1;
      tick();
      chk_idle("idle_norq");

      for (int i = 0; i < 9; i++)
         do_txn(vecs[i].rq, vecs[i].wr, vecs[i].mask, vecs[i].ackd,
                vecs[i].eg, vecs[i].ew, vecs[i].ewords, 1'b0);
      set_rq(3'b000, 3'b000, 4'b0000);

`ifdef MBOX_MEM_ARB_NXM_TIMEOUT_EN
      set_rq(3'b100, 3'b100, 4'b0000);
      tick();
      set_rq(3'b000, 3'b000, 4'b0000);
      chk("nxm_cnt0", {24'd0, bus.nxm_cnt}, 32'd0);
      repeat (63) tick();
      chk("nxm_cnt63", {24'd0, bus.nxm_cnt}, 32'd63);
      chk("nxm_pre_mstart", {31'd0, bus.mem_start}, 32'd1);
      tick();
      chk("nxm_err_set", {31'd0, bus.nxm_err}, 32'd1);
      chk("nxm_mstart", {31'd0, bus.mem_start}, 32'd0);
      chk("nxm_grant", {29'd0, bus.grant}, 32'd4);
      tick();
      chk("nxm_done", {31'd0, bus.done}, 32'd1);
      tick();
      chk_idle("nxm_idle");
      chk("nxm_sticky", {31'd0, bus.nxm_err}, 32'd1);
      bus.nxm_clr = 1'b1;
      tick();
      bus.nxm_clr = 1'b0;
      chk("nxm_clr", {31'd0, bus.nxm_err}, 32'd0);

      set_rq(3'b100, 3'b100, 4'b0000);
      tick();
      set_rq(3'b000, 3'b000, 4'b0000);
      repeat (63) tick();
      bus.ackn = 1'b1;
      tick();
      bus.ackn = 1'b0;
      chk("ack_at_limit_done", {31'd0, bus.done}, 32'd1);
      chk("ack_at_limit_err", {31'd0, bus.nxm_err}, 32'd0);
      tick();

      set_rq(3'b100, 3'b100, 4'b0000);
      tick();
      set_rq(3'b000, 3'b000, 4'b0000);
      repeat (63) tick();
      bus.nxm_clr = 1'b1;
      tick();
      bus.nxm_clr = 1'b0;
      chk("set_beats_clr", {31'd0, bus.nxm_err}, 32'd1);
      tick();
      tick();
      bus.nxm_clr = 1'b1;
      tick();
      bus.nxm_clr = 1'b0;
`else
      set_rq(3'b100, 3'b100, 4'b0000);
      tick();
      set_rq(3'b000, 3'b000, 4'b0000);
      repeat (200) tick();
      chk("no_nxm_busy", {31'd0, bus.core_busy}, 32'd1);
      chk("no_nxm_mstart", {31'd0, bus.mem_start}, 32'd1);
      chk("no_nxm_err", {31'd0, bus.nxm_err}, 32'd0);
      chk("no_nxm_cnt", {24'd0, bus.nxm_cnt}, 32'd0);
      bus.nxm_clr = 1'b1;
      tick();
      bus.nxm_clr = 1'b0;
      bus.ackn    = 1'b1;
      tick();
      bus.ackn    = 1'b0;
      chk("no_nxm_done", {31'd0, bus.done}, 32'd1);
      tick();
`endif

      set_rq(3'b001, 3'b000, 4'b1111);
      tick();
      bus.ackn = 1'b1;
      tick();
      bus.ackn = 1'b0;
      bus.data_valid = 1'b1;
      tick();
      tick();
      bus.data_valid = 1'b0;
      set_rq(3'b000, 3'b000, 4'b0000);
      chk("pre_rst_busy", {31'd0, bus.core_busy}, 32'd1);
      reset_n = 1'b0;
      tick();
      chk_idle("mid_rst");
      chk("mid_rst_err", {31'd0, bus.nxm_err}, 32'd0);
      chk("mid_rst_cnt", {24'd0, bus.nxm_cnt}, 32'd0);
      reset_n = 1'b1;
      bus.ackn = 1'b1;
      bus.data_valid = 1'b1;
      tick();
      tick();
      bus.ackn = 1'b0;
      bus.data_valid = 1'b0;
      chk_idle("late_dv");

      for (int t = 0; t < 40; t++) begin
         logic [2:0] rq;
         logic [2:0] wr;
         logic [3:0] mask;
         rq   = 3'($urandom_range(1, 7));
         wr   = 3'($urandom);
         mask = 4'($urandom);
         do_txn(rq, wr, mask, int'($urandom_range(0, 12)),
                m_owner(rq), m_wr(rq, wr), m_words(mask), 1'b1);
      end
      set_rq(3'b000, 3'b000, 4'b0000);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
